sha1_ctrl: RTL

Sequencer for the combinational SHA-1 round unit (`sha1`). It fetches one 512-bit message block from data memory over a request/grant port, then drives the round unit for 80 rounds. It expands the message schedule on the fly and adds the result into the chaining value H. It is started by `ex` (custom instruction path) and sits beside `sha1_assist`; its memory port is muxed onto the rib master port by the core top.

---
 rtl/sha1_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sha1_ctrl.sv
// SHA-1 block sequencer: fetches a 16-word block, drives an external combinational
// round unit for 80 rounds with an on-the-fly message schedule, then folds the result into H.
module sha1_ctrl #(
  parameter int          ADDR_W = 32,
  parameter logic [159:0] IV    = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              init_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_data_i,
  input  logic              mem_gnt_i,
  output logic [159:0]      round_state_o,
  output logic [31:0]       round_w_o,
  output logic [6:0]        round_t_o,
  input  logic [159:0]      round_state_i,
  output logic [159:0]      digest_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  // Five independent 32-bit additions; carries never cross word boundaries.
  function automatic logic [159:0] add_words(input logic [159:0] x, input logic [159:0] y);
    logic [159:0] s;
    s = 160'd0;
    for (int i = 0; i < 5; i++) begin
      s[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return s;
  endfunction

  state_t              state_r, next_state_s;
  logic [3:0]          k_r;
  logic [31:0]         wbuf_r [16];
  logic [159:0]        h_r;
  logic [159:0]        abcde_r;
  logic [31:0]         w_r;
  logic [6:0]          t_r;
  logic                busy_r, done_r, req_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                xfer_s, last_xfer_s;
  logic [6:0]          tn_s;
  logic [3:0]          tn_idx_s;
  logic [31:0]         w_next_s;

  assign xfer_s      = (state_r == ST_LOAD) && mem_gnt_i;
  assign last_xfer_s = xfer_s && (k_r == 4'd15);

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) next_state_s = ST_LOAD;
        else         next_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort_i)          next_state_s = ST_IDLE;
        else if (last_xfer_s) next_state_s = ST_ROUND;
        else                  next_state_s = ST_LOAD;
      end
      ST_ROUND: begin
        if (abort_i)             next_state_s = ST_IDLE;
        else if (t_r == 7'd79)   next_state_s = ST_FINAL;
        else                     next_state_s = ST_ROUND;
      end
      ST_FINAL: begin
        if (abort_i) next_state_s = ST_IDLE;
        else         next_state_s = ST_DONE;
      end
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Schedule word for the following round; the slot being written back this cycle is never a tap.
  always_comb begin
    tn_s     = t_r + 7'd1;
    tn_idx_s = tn_s[3:0];
    w_next_s = 32'd0;
    if (tn_s < 7'd16) begin
      w_next_s = wbuf_r[tn_idx_s];
    end else begin
      w_next_s = rotl1(wbuf_r[tn_idx_s - 4'd3] ^ wbuf_r[tn_idx_s - 4'd8] ^
                       wbuf_r[tn_idx_s - 4'd14] ^ wbuf_r[tn_idx_s]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Datapath: fetch, round sequencing, chaining-value update and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r     <= 4'd0;
      h_r     <= IV;
      abcde_r <= 160'd0;
      w_r     <= 32'd0;
      t_r     <= 7'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      req_r   <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      for (int i = 0; i < 16; i++) wbuf_r[i] <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            addr_r <= base_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
            k_r    <= 4'd0;
            req_r  <= 1'b1;
            if (init_i) h_r <= IV;
          end
        end
        ST_LOAD: begin
          if (abort_i) begin
            req_r <= 1'b0;
          end else if (mem_gnt_i) begin
            wbuf_r[k_r] <= mem_data_i;
            k_r         <= k_r + 4'd1;
            if (k_r == 4'd15) begin
              req_r   <= 1'b0;
              abcde_r <= h_r;
              t_r     <= 7'd0;
              w_r     <= wbuf_r[0];
            end else begin
              addr_r <= addr_r + {{(ADDR_W-3){1'b0}}, 3'b100};
            end
          end
        end
        ST_ROUND: begin
          if (!abort_i) begin
            abcde_r <= round_state_i;
            if (t_r >= 7'd16) wbuf_r[t_r[3:0]] <= w_r;
            if (t_r != 7'd79) begin
              t_r <= tn_s;
              w_r <= w_next_s;
            end
          end
        end
        ST_FINAL: begin
          if (!abort_i) h_r <= add_words(h_r, abcde_r);
        end
        default: begin
        end
      endcase
      busy_r <= (next_state_s != ST_IDLE);
      done_r <= (next_state_s == ST_DONE);
    end
  end

  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign mem_req_o     = req_r;
  assign mem_addr_o    = addr_r;
  assign round_state_o = abcde_r;
  assign round_w_o     = w_r;
  assign round_t_o     = t_r;
  assign digest_o      = h_r;

endmodule
